cpubus_mem_responder: RTL

//  Memory-side end of the 10-phase byte-serial CPU bus driven by the CPU handler.
//  - Deserialises the 32-bit address, 32-bit write data and the R/W flag.
//  - Commits writes to an internal 32-bit word register file.
//  - Serialises read data back over the shared 8-bit data lane, LSB byte first.
//  - Runs a phase counter in lockstep with the handler; both leave reset on the same edge.

---
 rtl/cpubus_mem_responder.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/cpubus_mem_responder.sv
// Memory end of the 10-phase byte-serial CPU bus: deserialises addr/wdata/flag, owns a word register file, serialises read data.
// Latency: write commits on the edge ending phase 5; read data is on the lane 1 cycle after the flag byte (phases 6..9, LSB first).
// Backpressure: none; runs in lockstep with the handler. Optional CPUBUS_BOUNDS_CHECK_EN adds a window check and err_cnt.
module cpubus_mem_responder #(
    parameter int          DEPTH     = 16,
    parameter int          IDX_W     = 4,
    parameter int          ADDR_LSB  = 2,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       bus_addr_in,
    input  logic [7:0]       bus_data_in,
    output logic [7:0]       bus_data_out,
    output logic [7:0]       bus_data_oe,
    input  logic             ld_we,
    input  logic [IDX_W-1:0] ld_idx,
    input  logic [31:0]      ld_data,
    output logic             frame_done,
    output logic [31:0]      last_addr,
    output logic             last_wr
`ifdef CPUBUS_BOUNDS_CHECK_EN
    ,
    output logic [7:0]       err_cnt
`endif
);

    localparam logic [3:0] PH_FLAG = 4'd5;
    localparam logic [3:0] PH_LAST = 4'd9;

    logic [3:0]       r_ph;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic [31:0]      r_rdata;
    logic             r_flag;
    logic [7:0]       r_oe;
    logic             r_frame_done;
    logic [31:0]      r_last_addr;
    logic             r_last_wr;
    logic [31:0]      r_mem [DEPTH];

    logic             w_end_flag;
    logic             w_flag_now;
    logic             w_in_range;
    logic [IDX_W-1:0] w_idx;
    logic             w_commit_wr;

    // The flag byte is consumed on the same edge that commits, so it is taken straight off the lane.
    assign w_end_flag = (r_ph == PH_FLAG);
    assign w_flag_now = bus_addr_in[0];

`ifdef CPUBUS_BOUNDS_CHECK_EN
    localparam logic [31:0] SPAN = 32'(DEPTH * 4);
    logic [31:0] w_off;
    logic [7:0]  r_err_cnt;

    // Offset-based compare avoids overflow of BASE_ADDR + SPAN near the top of the map.
    assign w_off      = r_addr - BASE_ADDR;
    assign w_in_range = (r_addr >= BASE_ADDR) && (w_off < SPAN);
    assign w_idx      = w_off[ADDR_LSB +: IDX_W];
    assign err_cnt    = r_err_cnt;

    // Count out-of-range frames once each at the flag edge; saturate rather than wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_cnt <= 8'h00;
        end else if (w_end_flag && !w_in_range && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end
`else
    logic w_unused_base;

    // Without the window check the upper address bits simply alias.
    assign w_in_range    = 1'b1;
    assign w_idx         = r_addr[ADDR_LSB +: IDX_W];
    assign w_unused_base = ^BASE_ADDR;
`endif

    assign w_commit_wr  = w_end_flag && w_flag_now && w_in_range;
    assign bus_data_oe  = r_oe;
    assign frame_done   = r_frame_done;
    assign last_addr    = r_last_addr;
    assign last_wr      = r_last_wr;

    // Phase counter, lockstep with the handler: 0..9 then wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ph <= 4'd0;
        end else if (r_ph == PH_LAST) begin
            r_ph <= 4'd0;
        end else begin
            r_ph <= r_ph + 4'd1;
        end
    end

    // Deserialise address/write data in phases 1..4 (byte 0 first) and the R/W flag in phase 5.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr  <= 32'h0;
            r_wdata <= 32'h0;
            r_flag  <= 1'b0;
        end else begin
            case (r_ph)
                4'd1: begin r_addr[7:0]   <= bus_addr_in; r_wdata[7:0]   <= bus_data_in; end
                4'd2: begin r_addr[15:8]  <= bus_addr_in; r_wdata[15:8]  <= bus_data_in; end
                4'd3: begin r_addr[23:16] <= bus_addr_in; r_wdata[23:16] <= bus_data_in; end
                4'd4: begin r_addr[31:24] <= bus_addr_in; r_wdata[31:24] <= bus_data_in; end
                4'd5: r_flag <= w_flag_now;
                default: ;
            endcase
        end
    end

    // Word store: preload first so a same-edge bus write to the same word overrides it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 32'h0;
            end
        end else begin
            if (ld_we) begin
                r_mem[ld_idx] <= ld_data;
            end
            if (w_commit_wr) begin
                r_mem[w_idx] <= r_wdata;
            end
        end
    end

    // Read capture, lane enable for phases 6..9 of reads, and end-of-frame status.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata      <= 32'h0;
            r_oe         <= 8'h00;
            r_frame_done <= 1'b0;
            r_last_addr  <= 32'h0;
            r_last_wr    <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (w_end_flag && !w_flag_now) begin
                r_rdata <= w_in_range ? r_mem[w_idx] : 32'h0;
                r_oe    <= 8'hFF;
            end
            if (r_ph == PH_LAST) begin
                r_oe         <= 8'h00;
                r_frame_done <= 1'b1;
                r_last_addr  <= r_addr;
                r_last_wr    <= r_flag;
            end
        end
    end

    // Read-data byte select; held for the whole phase so the handler's mid-phase sample is clean.
    always_comb begin
        bus_data_out = 8'h00;
        case (r_ph)
            4'd6: bus_data_out = r_rdata[7:0];
            4'd7: bus_data_out = r_rdata[15:8];
            4'd8: bus_data_out = r_rdata[23:16];
            4'd9: bus_data_out = r_rdata[31:24];
            default: bus_data_out = 8'h00;
        endcase
    end

endmodule
